// File: rtl/game_round_ctrl_if.sv
// Board-side bundle for the memory-tester round controller: player inputs
// (buttons, switches, authorisation) and the flash/status outputs.
interface game_round_ctrl_if #(
  parameter int MAX_LEN = 8
);
  localparam int IW = $clog2(MAX_LEN);

  logic          auth_bit;
  logic          button_pulse;
  logic [3:0]    level_num;
  logic          punch_button;
  logic [3:0]    toggle_answer;
  logic [3:0]    flash_num;
  logic          flash_valid;
  logic [IW-1:0] answer_idx;
  logic          busy;
  logic          win;
  logic          loose;

  modport master (
    output auth_bit, button_pulse, level_num, punch_button, toggle_answer,
    input  flash_num, flash_valid, answer_idx, busy, win, loose
  );

  modport slave (
    input  auth_bit, button_pulse, level_num, punch_button, toggle_answer,
    output flash_num, flash_valid, answer_idx, busy, win, loose
  );
endinterface

// File: rtl/game_round_ctrl.sv
// Memory-tester round controller: builds an LFSR symbol sequence, flashes it,
// then checks the player's answers and reports win or loose.
//
// state     | meaning
// IDLE      | waiting for an authorised start edge
// LOAD      | writing L symbols from the LFSR into the sequence RAM
// FLASH_ON  | showing seq[idx] for FLASH_CYC cycles
// FLASH_GAP | blank for GAP_CYC cycles between symbols
// ANSWER    | collecting punched answers, timeout timer running
// WIN       | whole sequence matched, win held
// LOSE      | mismatch or timeout, loose held
module game_round_ctrl #(
  parameter int         MAX_LEN     = 8,
  parameter int         FLASH_CYC   = 4,
  parameter int         GAP_CYC     = 2,
  parameter int         TIMEOUT_CYC = 64,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input logic             clock,
  input logic             rst,
  game_round_ctrl_if.slave bus
);
  localparam int IW      = $clog2(MAX_LEN);
  localparam int LW      = IW + 1;
  localparam int CNT_MAX = (TIMEOUT_CYC > FLASH_CYC)
                           ? ((TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC)
                           : ((FLASH_CYC > GAP_CYC) ? FLASH_CYC : GAP_CYC);
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_FLASH_ON, ST_FLASH_GAP, ST_ANSWER, ST_WIN, ST_LOSE
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic          btn_prev_q, btn_prev_d;
  logic          punch_prev_q, punch_prev_d;
  logic [3:0]    flash_num_q, flash_num_d;
  logic          flash_valid_q, flash_valid_d;
  logic [IW-1:0] answer_idx_q, answer_idx_d;
  logic          busy_q, busy_d;
  logic          win_q, win_d;
  logic          loose_q, loose_d;
  logic [3:0]    seq_q [MAX_LEN];

  logic          seq_we;
  logic          start_edge, punch_edge;
  logic          idx_last, ans_last;
  logic [4:0]    lvl_ext;
  logic [LW-1:0] len_req;

  always_comb begin
    start_edge = bus.button_pulse & ~btn_prev_q;
    punch_edge = bus.punch_button & ~punch_prev_q;
    idx_last   = ({1'b0, idx_q} == len_q - LW'(1));
    ans_last   = ({1'b0, answer_idx_q} == len_q - LW'(1));
    lvl_ext    = {1'b0, bus.level_num};
    if (bus.level_num == 4'd0)      len_req = LW'(1);
    else if (lvl_ext > 5'(MAX_LEN)) len_req = LW'(MAX_LEN);
    else                            len_req = LW'(lvl_ext);
  end

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    lfsr_d        = lfsr_q;
    btn_prev_d    = bus.button_pulse;
    punch_prev_d  = bus.punch_button;
    flash_num_d   = flash_num_q;
    flash_valid_d = flash_valid_q;
    answer_idx_d  = answer_idx_q;
    win_d         = win_q;
    loose_d       = loose_q;
    seq_we        = 1'b0;
    if (!bus.auth_bit) begin
      state_d       = ST_IDLE;
      idx_d         = '0;
      flash_num_d   = 4'h0;
      flash_valid_d = 1'b0;
      answer_idx_d  = '0;
      win_d         = 1'b0;
      loose_d       = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_WIN, ST_LOSE: begin
          if (start_edge) begin
            state_d      = ST_LOAD;
            len_d        = len_req;
            idx_d        = '0;
            answer_idx_d = '0;
            win_d        = 1'b0;
            loose_d      = 1'b0;
          end
        end
        ST_LOAD: begin
          seq_we = 1'b1;
          lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
          if (idx_last) begin
            state_d       = ST_FLASH_ON;
            idx_d         = '0;
            cnt_d         = CW'(FLASH_CYC - 1);
            // A one-symbol round is still being written this cycle, so bypass the RAM.
            flash_num_d   = (idx_q == '0) ? lfsr_q[3:0] : seq_q[0];
            flash_valid_d = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        ST_FLASH_ON: begin
          if (cnt_q == '0) begin
            state_d       = ST_FLASH_GAP;
            cnt_d         = CW'(GAP_CYC - 1);
            flash_num_d   = 4'h0;
            flash_valid_d = 1'b0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_FLASH_GAP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else if (idx_last) begin
            state_d      = ST_ANSWER;
            answer_idx_d = '0;
            cnt_d        = CW'(TIMEOUT_CYC - 1);
          end else begin
            state_d       = ST_FLASH_ON;
            idx_d         = idx_q + IW'(1);
            cnt_d         = CW'(FLASH_CYC - 1);
            flash_num_d   = seq_q[idx_q + IW'(1)];
            flash_valid_d = 1'b1;
          end
        end
        ST_ANSWER: begin
          // A punch landing on the expiry cycle still counts.
          if (punch_edge) begin
            if (bus.toggle_answer != seq_q[answer_idx_q]) begin
              state_d = ST_LOSE;
              loose_d = 1'b1;
            end else if (ans_last) begin
              state_d = ST_WIN;
              win_d   = 1'b1;
            end else begin
              answer_idx_d = answer_idx_q + IW'(1);
              cnt_d        = CW'(TIMEOUT_CYC - 1);
            end
          end else if (cnt_q == '0) begin
            state_d = ST_LOSE;
            loose_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = state_d inside {ST_LOAD, ST_FLASH_ON, ST_FLASH_GAP, ST_ANSWER};
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      len_q         <= LW'(1);
      idx_q         <= '0;
      cnt_q         <= '0;
      lfsr_q        <= LFSR_SEED;
      btn_prev_q    <= 1'b1;
      punch_prev_q  <= 1'b1;
      flash_num_q   <= 4'h0;
      flash_valid_q <= 1'b0;
      answer_idx_q  <= '0;
      busy_q        <= 1'b0;
      win_q         <= 1'b0;
      loose_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      lfsr_q        <= lfsr_d;
      btn_prev_q    <= btn_prev_d;
      punch_prev_q  <= punch_prev_d;
      flash_num_q   <= flash_num_d;
      flash_valid_q <= flash_valid_d;
      answer_idx_q  <= answer_idx_d;
      busy_q        <= busy_d;
      win_q         <= win_d;
      loose_q       <= loose_d;
      if (seq_we) seq_q[idx_q] <= lfsr_q[3:0];
    end
  end

  assign bus.flash_num   = flash_num_q;
  assign bus.flash_valid = flash_valid_q;
  assign bus.answer_idx  = answer_idx_q;
  assign bus.busy        = busy_q;
  assign bus.win         = win_q;
  assign bus.loose       = loose_q;
endmodule

// File: tb/tb_game_round_ctrl.sv
// Randomized bench for game_round_ctrl: a queue-based model predicts each round's
// symbol list and the flash/answer timeline from the round rules.
module tb_game_round_ctrl;
  localparam int         MAX_LEN     = 8;
  localparam int         FLASH_CYC   = 4;
  localparam int         GAP_CYC     = 2;
  localparam int         TIMEOUT_CYC = 64;
  localparam logic [7:0] LFSR_SEED   = 8'hA5;
  localparam int         IW          = $clog2(MAX_LEN);
  localparam int         OW          = 4 + 1 + IW + 3;
  localparam int         SLOT        = FLASH_CYC + GAP_CYC;

  logic clock = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [7:0] m_lfsr;
  logic [3:0] m_seq[$];
  int         m_len;

  always #5 clock = ~clock;

  game_round_ctrl_if #(.MAX_LEN(MAX_LEN)) bus ();

  game_round_ctrl #(
    .MAX_LEN(MAX_LEN), .FLASH_CYC(FLASH_CYC), .GAP_CYC(GAP_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC), .LFSR_SEED(LFSR_SEED)
  ) dut (
    .clock(clock),
    .rst  (rst),
    .bus  (bus)
  );

  function automatic logic [OW-1:0] pk(input logic [3:0] num, input logic vld,
                                       input logic [IW-1:0] idx, input logic bsy,
                                       input logic w, input logic l);
    return {num, vld, idx, bsy, w, l};
  endfunction

  function automatic logic [OW-1:0] dut_outs();
    return {bus.flash_num, bus.flash_valid, bus.answer_idx, bus.busy, bus.win, bus.loose};
  endfunction

  // End-of-round view: answer_idx is not part of the win/loose contract.
  function automatic logic [7:0] dut_end();
    return {bus.flash_num, bus.flash_valid, bus.busy, bus.win, bus.loose};
  endfunction

  function automatic int clamp_len(input int lv);
    if (lv == 0) return 1;
    if (lv > MAX_LEN) return MAX_LEN;
    return lv;
  endfunction

  task automatic gen_seq(input int len);
    m_seq.delete();
    for (int i = 0; i < len; i++) begin
      m_seq.push_back(m_lfsr[3:0]);
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  endtask

  task automatic punch(input logic [3:0] v);
    bus.toggle_answer = v;
    bus.punch_button  = 1'b1;
    @(negedge clock);
    bus.punch_button  = 1'b0;
  endtask

  // Starts a round and follows it through the flash phase; abort_at >= 0 drops auth there.
  task automatic run_flash(input int lv, input bit disturb, input int abort_at);
    int total, dj, t;
    logic [OW-1:0] e;
    m_len = clamp_len(lv);
    gen_seq(m_len);
    total = m_len + m_len * SLOT;
    dj = disturb ? int'($urandom_range(total - 3, 2)) : -1;
    bus.level_num    = 4'(lv);
    bus.button_pulse = 1'b1;
    for (int j = 0; j < total; j++) begin
      @(negedge clock);
      if (j < m_len) begin
        e = pk(4'h0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
      end else begin
        t = j - m_len;
        if ((t % SLOT) < FLASH_CYC) e = pk(m_seq[t / SLOT], 1'b1, '0, 1'b1, 1'b0, 1'b0);
        else                        e = pk(4'h0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
      end
      n_cmp++;
      if (dut_outs() !== e) begin
        n_bad++;
        $display("FAIL flash_phase L=%0d j=%0d got %h expected %h", m_len, j, dut_outs(), e);
      end
      bus.button_pulse = (j == dj);
      bus.punch_button = (j == dj);
      if (j == dj) bus.level_num = 4'($urandom_range(15, 0));
      if (j == abort_at) begin
        bus.auth_bit = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (dut_outs() !== pk(4'h0, 1'b0, '0, 1'b0, 1'b0, 1'b0)) begin
          n_bad++;
          $display("FAIL auth_abort j=%0d got %h expected all zero", j, dut_outs());
        end
        bus.auth_bit = 1'b1;
        return;
      end
    end
    @(negedge clock);
    n_cmp++;
    if (dut_outs() !== pk(4'h0, 1'b0, '0, 1'b1, 1'b0, 1'b0)) begin
      n_bad++;
      $display("FAIL answer_entry L=%0d got %h expected %h", m_len, dut_outs(),
               pk(4'h0, 1'b0, '0, 1'b1, 1'b0, 1'b0));
    end
  endtask

  // Correct answers for entries from_k..to_k-1 with random idle gaps.
  task automatic answer_range(input int from_k, input int to_k);
    int d;
    for (int k = from_k; k < to_k; k++) begin
      d = $urandom_range(4, 1);
      for (int i = 0; i < d; i++) begin
        @(negedge clock);
        n_cmp++;
        if (dut_outs() !== pk(4'h0, 1'b0, IW'(k), 1'b1, 1'b0, 1'b0)) begin
          n_bad++;
          $display("FAIL answer_wait k=%0d got %h expected idx %0d busy", k, dut_outs(), k);
        end
      end
      punch(m_seq[k]);
      n_cmp++;
      if (k < m_len - 1) begin
        if (dut_outs() !== pk(4'h0, 1'b0, IW'(k + 1), 1'b1, 1'b0, 1'b0)) begin
          n_bad++;
          $display("FAIL answer_step k=%0d got %h expected idx %0d", k, dut_outs(), k + 1);
        end
      end else if (dut_end() !== 8'b0000_0_0_1_0) begin
        n_bad++;
        $display("FAIL win_flag got %h expected 02 (win only)", dut_end());
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.auth_bit = 1'b1;
    bus.button_pulse = 1'b1;
    bus.punch_button = 1'b1;
    bus.level_num = 4'd5;
    bus.toggle_answer = 4'd0;
    repeat (3) @(negedge clock);
    n_cmp++;
    if (dut_outs() !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got %h expected 0", dut_outs());
    end
    rst = 1'b1;
    m_lfsr = LFSR_SEED;
    repeat (3) begin
      @(negedge clock);
      n_cmp++;
      if (dut_outs() !== '0) begin
        n_bad++;
        $display("FAIL held_inputs_no_edge got %h expected 0", dut_outs());
      end
    end
    bus.button_pulse = 1'b0;
    bus.punch_button = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_first_game();
    run_flash(5, 1'b0, -1);
    answer_range(0, m_len);
  endtask

  task automatic test_back_to_back();
    repeat (6) begin
      run_flash(int'($urandom_range(15, 0)), 1'b1, -1);
      answer_range(0, m_len);
    end
  endtask

  task automatic test_lose();
    int w;
    repeat (4) begin
      run_flash(int'($urandom_range(15, 1)), 1'b1, -1);
      w = $urandom_range(m_len - 1, 0);
      answer_range(0, w);
      @(negedge clock);
      punch(m_seq[w] ^ 4'($urandom_range(15, 1)));
      n_cmp++;
      if (dut_end() !== 8'b0000_0_0_0_1) begin
        n_bad++;
        $display("FAIL lose_flag w=%0d got %h expected 01", w, dut_end());
      end
      @(negedge clock);
      punch(m_seq[w]);
      n_cmp++;
      if (dut_end() !== 8'b0000_0_0_0_1) begin
        n_bad++;
        $display("FAIL punch_after_lose got %h expected 01", dut_end());
      end
    end
  endtask

  task automatic test_timeout();
    run_flash(int'($urandom_range(15, 1)), 1'b0, -1);
    for (int i = 1; i <= TIMEOUT_CYC; i++) begin
      @(negedge clock);
      n_cmp++;
      if (i < TIMEOUT_CYC) begin
        if (dut_outs() !== pk(4'h0, 1'b0, '0, 1'b1, 1'b0, 1'b0)) begin
          n_bad++;
          $display("FAIL timeout_early i=%0d got %h expected busy", i, dut_outs());
        end
      end else if (dut_end() !== 8'b0000_0_0_0_1) begin
        n_bad++;
        $display("FAIL timeout_lose got %h expected 01", dut_end());
      end
    end
    run_flash(int'($urandom_range(15, 2)), 1'b0, -1);
    repeat (TIMEOUT_CYC - 1) @(negedge clock);
    punch(m_seq[0]);
    n_cmp++;
    if (dut_outs() !== pk(4'h0, 1'b0, IW'(1), 1'b1, 1'b0, 1'b0)) begin
      n_bad++;
      $display("FAIL punch_at_expiry got %h expected idx 1 busy", dut_outs());
    end
    for (int i = 1; i <= TIMEOUT_CYC; i++) begin
      @(negedge clock);
      n_cmp++;
      if (i < TIMEOUT_CYC) begin
        if (dut_outs() !== pk(4'h0, 1'b0, IW'(1), 1'b1, 1'b0, 1'b0)) begin
          n_bad++;
          $display("FAIL timer_cleared i=%0d got %h expected busy idx 1", i, dut_outs());
        end
      end else if (dut_end() !== 8'b0000_0_0_0_1) begin
        n_bad++;
        $display("FAIL timeout_after_match got %h expected 01", dut_end());
      end
    end
  endtask

  task automatic test_level_bounds();
    int lvls[6] = '{0, 1, MAX_LEN, MAX_LEN + 1, 12, 15};
    for (int i = 0; i < 6; i++) begin
      run_flash(lvls[i], 1'b0, -1);
      answer_range(0, m_len);
    end
  endtask

  task automatic test_auth();
    int ab;
    m_len = clamp_len(int'($urandom_range(15, 1)));
    ab = m_len + int'($urandom_range(m_len - 1, 0)) * SLOT + int'($urandom_range(FLASH_CYC - 1, 0));
    run_flash(m_len, 1'b0, ab);
    bus.auth_bit = 1'b0;
    bus.button_pulse = 1'b1;
    @(negedge clock);
    bus.button_pulse = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (dut_outs() !== '0) begin
      n_bad++;
      $display("FAIL start_without_auth got %h expected 0", dut_outs());
    end
    bus.auth_bit = 1'b1;
    @(negedge clock);
    run_flash(1, 1'b0, -1);
    punch(~m_seq[0]);
    bus.auth_bit = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (dut_end() !== 8'h00) begin
      n_bad++;
      $display("FAIL auth_clears_loose got %h expected 00", dut_end());
    end
    bus.auth_bit = 1'b1;
    @(negedge clock);
    run_flash(int'($urandom_range(15, 0)), 1'b1, -1);
    answer_range(0, m_len);
  endtask

  task automatic test_reset_mid();
    run_flash(int'($urandom_range(15, 2)), 1'b0, -1);
    answer_range(0, 1);
    rst = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (dut_outs() !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_answer got %h expected 0", dut_outs());
    end
    @(negedge clock);
    rst = 1'b1;
    m_lfsr = LFSR_SEED;
    @(negedge clock);
    run_flash(5, 1'b0, -1);
    answer_range(0, m_len);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_game();
    test_back_to_back();
    test_lose();
    test_timeout();
    test_level_bounds();
    test_auth();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
